// File: rtl/computie_bus_pkg.sv
// Shared definitions for the computie bus master and device controllers.
package computie_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        DATA,
        RELEASE
    } bus_state_e;

    localparam logic BUS_SEND     = 1'b1;
    localparam logic BUS_RECEIVE  = 1'b0;
    localparam logic DIR_TO_BUS   = 1'b1;
    localparam logic DIR_FROM_BUS = 1'b0;

endpackage

// File: rtl/computie_bus_sync.sv
// Two-flop synchronizer for asynchronous bus handshake inputs, with a
// configurable reset value so idle-high strobes come up deasserted.
module computie_bus_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/computie_bus_master.sv
// Initiator for the multiplexed computie bus: one full address/data cycle per
// request, with ack/berr handshake, timeout and registered bus controls.
module computie_bus_master
    import computie_bus_pkg::*;
#(
    parameter int BITWIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [BITWIDTH-1:0] req_addr,
    input  logic [BITWIDTH-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [BITWIDTH-1:0] rsp_rdata,
    output logic                rsp_error,
    output logic                addr_strobe,
    output logic                read_write,
    input  logic                data_ack_n,
    input  logic                bus_error_n,
    output logic                send_receive,
    output logic                addr_oe,
    output logic                data_oe,
    output logic                data_dir,
    output logic                demux_oe,
    input  logic [BITWIDTH-1:0] from_bus,
    output logic [BITWIDTH-1:0] to_bus
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic ack_s, berr_s;

    computie_bus_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_ack_sync (
        .clk     (clk),
        .rst_n   (reset_n),
        .async_i (data_ack_n),
        .sync_o  (ack_s)
    );

    computie_bus_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_berr_sync (
        .clk     (clk),
        .rst_n   (reset_n),
        .async_i (bus_error_n),
        .sync_o  (berr_s)
    );

    bus_state_e          state_q, state_d;
    logic [BITWIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [BITWIDTH-1:0] to_bus_q, to_bus_d;
    logic                write_q, write_d, err_q, err_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ready_q, ready_d, rvld_q, rvld_d, rerr_q, rerr_d;
    logic                as_q, as_d, rw_q, rw_d, sr_q, sr_d;
    logic                aoe_q, aoe_d, doe_q, doe_d, ddir_q, ddir_d, dmx_q, dmx_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    err_d   = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR:   state_d = STROBE;
            STROBE: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                // Bus error wins over ack, ack wins over timeout.
                if (!berr_s) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else if (!ack_s) begin
                    if (!write_q) rdata_d = from_bus;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for the target to let go, but never forever.
                cnt_d = cnt_q + 1'b1;
                if ((ack_s && berr_s) || cnt_q == CNT_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered from the next state so they line up
        // with the state the FSM is actually in.
        ready_d = (state_d == IDLE);
        rvld_d  = (state_q == RELEASE) && (state_d == IDLE);
        rerr_d  = rvld_d ? err_q : rerr_q;
        as_d    = !((state_d == STROBE) || (state_d == DATA));
        rw_d    = (state_d == IDLE) ? 1'b1 : ~write_d;
        sr_d    = ((state_d == ADDR) || (state_d == STROBE) || (state_d == DATA))
                  ? BUS_SEND : BUS_RECEIVE;
        aoe_d   = (state_d == ADDR) || (state_d == STROBE);
        doe_d   = (state_d == DATA);
        ddir_d  = ((state_d == DATA) && write_d) ? DIR_TO_BUS : DIR_FROM_BUS;
        dmx_d   = aoe_d || ((state_d == DATA) && write_d);
        if (aoe_d)
            to_bus_d = addr_d;
        else if ((state_d == DATA) && write_d)
            to_bus_d = wdata_d;
        else
            to_bus_d = to_bus_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            to_bus_q <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rvld_q   <= 1'b0;
            rerr_q   <= 1'b0;
            as_q     <= 1'b1;
            rw_q     <= 1'b1;
            sr_q     <= BUS_RECEIVE;
            aoe_q    <= 1'b0;
            doe_q    <= 1'b0;
            ddir_q   <= DIR_FROM_BUS;
            dmx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            to_bus_q <= to_bus_d;
            write_q  <= write_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvld_q   <= rvld_d;
            rerr_q   <= rerr_d;
            as_q     <= as_d;
            rw_q     <= rw_d;
            sr_q     <= sr_d;
            aoe_q    <= aoe_d;
            doe_q    <= doe_d;
            ddir_q   <= ddir_d;
            dmx_q    <= dmx_d;
        end
    end

    assign req_ready    = ready_q;
    assign rsp_valid    = rvld_q;
    assign rsp_error    = rerr_q;
    assign rsp_rdata    = rdata_q;
    assign addr_strobe  = as_q;
    assign read_write   = rw_q;
    assign send_receive = sr_q;
    assign addr_oe      = aoe_q;
    assign data_oe      = doe_q;
    assign data_dir     = ddir_q;
    assign demux_oe     = dmx_q;
    assign to_bus       = to_bus_q;

endmodule

// File: doc/computie_bus_master.md
# computie_bus_master

Initiator-side controller for the multiplexed computie bus: accepts single read/write requests from internal FPGA logic and runs one complete bus cycle per request. It drives address strobe and read/write, sequences the address and data phases onto the shared demux path, and controls the transceivers. It waits for the target's data acknowledge or bus error, with a timeout. It is the counterpart of the existing bus device controller and sits between an internal CPU/DMA core and the board transceivers.

## Interface
- BITWIDTH, 32, width of address and data words on the multiplexed path
- TIMEOUT_CYCLES, 255, DATA-state cycles without ack/error before the cycle aborts with error; must be ≥ 1

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on the edge where req_valid && req_ready
- req_write  in  1  1 = write to bus, 0 = read from bus
- req_addr  in  BITWIDTH  target address
- req_wdata  in  BITWIDTH  write data
- rsp_valid  out  1  one-cycle pulse at cycle end
- rsp_rdata  out  BITWIDTH  read data; valid with rsp_valid on reads, held until the next read completes
- rsp_error  out  1  valid with rsp_valid: bus error or timeout
- addr_strobe  out  1  bus AS, active low
- read_write  out  1  bus R/W: 1 = read, 0 = write
- data_ack_n  in  1  target acknowledge, active low, asynchronous to clk
- bus_error_n  in  1  bus error, active low, asynchronous to clk
- send_receive  out  1  transceiver direction, 1 = send
- addr_oe, data_oe  out  1  address/data transceiver enables, active high
- data_dir  out  1  data transceiver direction, 1 = FPGA→bus
- demux_oe  out  1  1 = FPGA drives to_bus onto the demux path
- from_bus  in  BITWIDTH  demuxed bus input
- to_bus  out  BITWIDTH  demuxed bus output

## Operation
- data_ack_n and bus_error_n pass through 2-flop synchronizers, reset to 1; ack_s and berr_s denote the synchronized values.
- IDLE: req_ready=1, AS=1, all enables 0. On accept, latch addr, wdata and write. Go to ADDR.
- ADDR (1 cycle): to_bus=addr, demux_oe=1, send_receive=1, addr_oe=1, read_write=~write. Go to STROBE.
- STROBE (1 cycle): addr_strobe=0; address still driven (hold). Go to DATA; clear timeout counter.
- DATA: addr_oe=0, data_oe=1, data_dir=write.
  - Write: to_bus=wdata, demux_oe=1.
  - Read: demux_oe=0.
  - Counter increments each cycle.
  - Exit conditions:
    - berr_s=0 → error=1.
    - ack_s=0 → capture from_bus into rsp_rdata if read.
    - Counter reaches TIMEOUT_CYCLES → error=1.
  - Priority when simultaneous: berr > ack > timeout. Every exit goes to RELEASE.
- RELEASE: addr_strobe=1, data_oe=0, demux_oe=0, send_receive=0. Stay while ack_s=0 or berr_s=0, but at most TIMEOUT_CYCLES cycles, then go to IDLE. rsp_valid pulses in the first IDLE cycle.
- read_write holds its value from ADDR through RELEASE, and returns to 1 in IDLE.
- Error cycles of either type leave rsp_rdata unchanged.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, addr_strobe=1, read_write=1, send_receive=0, addr_oe=0, data_oe=0, data_dir=0, demux_oe=0, to_bus=0.
- All outputs are registered.
- Address is valid on the bus one cycle before AS falls and is held one cycle after.
- The ack pin to DATA-state detection takes 2 cycles (synchronizer).
- A request presented during RELEASE or on the rsp_valid cycle is not accepted until req_ready is high.
- A back-to-back request can be accepted on the same edge as rsp_valid.
- Asserting reset_n mid-cycle immediately releases AS and all enables, and no rsp_valid is generated.

## Structure
- Shared package computie_bus_pkg holds:
  - the state enum: IDLE, ADDR, STROBE, DATA, RELEASE
  - constants BUS_SEND=1, BUS_RECEIVE=0, DIR_TO_BUS=1, DIR_FROM_BUS=0
  - these constants are shared with the device controller
- Sub-module computie_bus_sync: parameterised 2-flop synchronizer with reset value, instanced for data_ack_n and bus_error_n.

## Test plan
- Read, target acks 3 cycles after AS fall with from_bus=32'hDEADBEEF → one rsp_valid, rsp_rdata=32'hDEADBEEF, rsp_error=0, read_write=1 throughout.
- Write addr=32'h00100004, wdata=32'h12345678 → to_bus shows the address in ADDR/STROBE, then the data with data_dir=1, read_write=0. Ack gives rsp_error=0.
- TIMEOUT_CYCLES=16 with no ack → AS released after exactly 16 DATA cycles, rsp_error=1, rsp_rdata unchanged.
- ack and berr asserted on the same clock → rsp_error=1 and no read-data capture.
- Target holds ack low 5 cycles after AS rises → rsp_valid is delayed until ack_s=1, and no new AS occurs before that.
- reset_n low during DATA → addr_strobe=1 and all enables 0 asynchronously. After release, IDLE with req_ready=1 and no rsp_valid.
